alu_serial_rx: RTL and testbench
================================

Name: alu_serial_rx

Overview:
Parametrised serial command receiver for the ALU datapath. Deserialises the single-wire `sin` frame protocol into N operands of DATA_W bits plus a 3-bit opcode. Checks frame structure, packet length, CRC4 and opcode validity, then presents one result record on a valid/ready interface to the ALU core. Generalises the fixed two-operand, 32-bit front end to any operand count and width.

Parameters:
DATA_W, 32, operand width in bits; must be a multiple of 8 and at least 8
N_OPERANDS, 2, operands per packet; must be at least 1
BYTES_PER_PKT, (DATA_W/8)*N_OPERANDS, derived localparam: data frames expected per packet

Ports:
clk  in  1  system clock; `sin` is sampled on each rising edge
rst_n  in  1  asynchronous, active-low reset
sin  in  1  serial input; idles high; one bit per clock
out_valid  out  1  result record valid
out_ready  in  1  consumer accepts the record when high together with out_valid
out_data  out  N_OPERANDS*DATA_W  operands, packed; first-received byte at the MSB
out_op  out  3  opcode from the CMD frame
out_err  out  3  {err_data, err_crc, err_op}; at most one bit set
overrun  out  1  one-cycle pulse when a completed record is dropped

Behaviour:
- Reset: out_valid=0, out_data=0, out_op=0, out_err=0, overrun=0. Frame FSM goes to IDLE and the byte counter to 0. Reset mid-frame or mid-packet discards all partial state.
- Frame format: 11 bits, MSB first: start 0, type (0 = DATA, 1 = CMD), 8 payload bits, stop 1.
- Frame FSM:
  - IDLE: on sin=0 go to TYPE.
  - TYPE: latch the type bit, go to BITS.
  - BITS: shift 8 bits, go to STOP.
  - STOP: if sin=1 the frame is good; if sin=0 it is a frame error and the FSM goes to WAIT_HI.
  - After STOP the FSM returns to IDLE.
  - WAIT_HI: return to IDLE once sin=1.
- DATA frame: the byte shifts into the operand shift register. The byte count increments and saturates at BYTES_PER_PKT+1.
- CMD frame payload: bit7 is ignored; bits6:4 are op; bits3:0 are crc.
- Packet completion:
  - On a CMD frame, or on a frame error, a record completes.
  - The record is registered and out_valid rises on the clock edge after the edge that sampled the stop bit.
- Error priority, only the highest is set:
  - err_data: frame error, or byte count != BYTES_PER_PKT at CMD.
  - err_crc: CRC mismatch.
  - err_op: op not in {AND=000, OR=001, ADD=100, SUB=101}.
  - When any error is set, out_data and out_op hold 0.
- CRC4:
  - Polynomial x^4+x+1, init 0, computed serially over {out_data MSB-first, 1'b1, op}.
  - Per bit: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
- Packet state (byte count, shift register) clears after every completed record.
- Handshake:
  - The record stays stable while out_valid=1 and out_ready=0.
  - out_valid drops on the edge where out_valid and out_ready are both 1, unless a new record loads on that same edge.
  - Simultaneous accept and new completion: the new record loads and out_valid stays 1.
- Overrun: a record completes while out_valid=1 and out_ready=0. The new record is dropped, the held record is kept, and overrun pulses for 1 cycle.
- A CMD frame with zero preceding DATA frames gives err_data.
- DATA frames beyond BYTES_PER_PKT keep shifting; the oldest bytes are lost and the packet ends in err_data.

Decomposition:
- alu_pkg holds:
  - the op_t enum (AND, OR, ADD, SUB encodings)
  - the err_t struct {err_data, err_crc, err_op}
  - FRAME_DATA/FRAME_CMD constants
  - the CRC4 polynomial constant and a crc4_next() function shared with the transmitter and the bench.
- Sub-module alu_frame_rx: the bit-level frame FSM. Outputs byte[7:0], is_cmd, frame_vld and frame_err as 1-cycle strobes.
- Top level: packet counting, CRC, error priority, output register and handshake.

Test Plan:
- DATA_W=32, N=2: 8 DATA frames of 0x00, then CMD 0x0B (op=AND, crc=0xB), out_ready=1. Expect out_valid one cycle after the stop bit; out_data=64'h0, out_op=000, out_err=000.
- Same packet with CMD 0x0A -> out_err=3'b010 (err_crc), out_data=0.
- 8 zero DATA frames, then CMD 0x2D (op=010, crc correct=0xD) -> out_err=3'b001 (err_op).
- 7 DATA frames, then CMD 0x0B -> err_data=1. Separately, a stop bit of 0 in DATA frame 3 -> err_data; a following valid packet decodes cleanly.
- out_ready=0 while two good packets complete -> the first record is held unchanged and overrun pulses once for the second. Raise out_ready -> out_valid falls the next edge.
- DATA_W=16, N=3: 6 DATA frames 0x12,0x34,0x56,0x78,0x9A,0xBC plus a correct CMD (ADD, CRC from crc4_next) -> out_data=48'h123456789ABC. Assert rst_n=0 mid-frame -> outputs 0 and the next packet is received cleanly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial command link: opcodes, error flags,
// frame-type codes, the receive frame FSM states and the CRC4 helpers used by
// the receiver, the transmitter and their benches.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  // Bit order matches the out_err port: {err_data, err_crc, err_op}.
  typedef struct packed {
    logic err_data;
    logic err_crc;
    logic err_op;
  } err_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_TYPE,
    FS_BITS,
    FS_STOP,
    FS_WAIT_HI
  } frame_state_t;

  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CMD  = 1'b1;

  // x^4 + x + 1, with the x^4 term implied by the shift.
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Bit-level frame receiver for the sin line: start(0), type, 8 payload bits
// MSB first, stop(1). Ports: clk/rst_n, sin in; frame_byte/is_cmd hold the last
// frame, frame_vld/frame_err are 1-cycle strobes issued the cycle after the stop bit.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [7:0] frame_byte,
  output logic       is_cmd,
  output logic       frame_vld,
  output logic       frame_err
);

  frame_state_t state, state_nxt;
  logic [2:0]   bit_cnt;
  logic         vld_nxt, err_nxt;

  always_comb begin
    state_nxt = state;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      FS_IDLE:    if (!sin) state_nxt = FS_TYPE;
      FS_TYPE:    state_nxt = FS_BITS;
      FS_BITS:    if (bit_cnt == 3'd7) state_nxt = FS_STOP;
      FS_STOP: begin
        if (sin) begin
          vld_nxt   = 1'b1;
          state_nxt = FS_IDLE;
        end else begin
          // A low stop bit may be the middle of a broken frame: resync on idle.
          err_nxt   = 1'b1;
          state_nxt = FS_WAIT_HI;
        end
      end
      FS_WAIT_HI: if (sin) state_nxt = FS_IDLE;
      default:    state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FS_IDLE;
      bit_cnt    <= 3'd0;
      frame_byte <= 8'h00;
      is_cmd     <= 1'b0;
      frame_vld  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_vld <= vld_nxt;
      frame_err <= err_nxt;
      if (state == FS_TYPE) is_cmd <= (sin == FRAME_CMD);
      if (state == FS_BITS) begin
        frame_byte <= {frame_byte[6:0], sin};
        bit_cnt    <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/alu_serial_rx.sv
// Serial command receiver: collects DATA frames into N_OPERANDS operands, closes
// the packet on a CMD frame or frame error, checks length/CRC4/opcode and offers
// one record on out_valid/out_ready. Ports: clk, rst_n, sin, record outputs, overrun.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int N_OPERANDS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OPERANDS*DATA_W-1:0] out_data,
  output logic [2:0]                   out_op,
  output logic [2:0]                   out_err,
  output logic                         overrun
);

  localparam int BYTES_PER_PKT = (DATA_W / 8) * N_OPERANDS;
  localparam int PKT_W         = N_OPERANDS * DATA_W;
  localparam int CNT_W         = $clog2(BYTES_PER_PKT + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_PKT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BYTES_PER_PKT + 1);

  logic [7:0]       frame_byte;
  logic             is_cmd, frame_vld, frame_err;
  logic [PKT_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       crc_calc;
  logic [2:0]       cmd_op;
  err_t             rec_err;
  logic             complete, data_push, any_err;

  alu_frame_rx u_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .frame_byte (frame_byte),
    .is_cmd     (is_cmd),
    .frame_vld  (frame_vld),
    .frame_err  (frame_err)
  );

  assign cmd_op    = frame_byte[6:4];
  assign data_push = frame_vld && !is_cmd;
  assign complete  = (frame_vld && is_cmd) || frame_err;

  // CRC over {operands MSB first, 1'b1, op}; only meaningful on a CMD strobe.
  always_comb begin
    crc_calc = 4'h0;
    for (int i = PKT_W - 1; i >= 0; i--) crc_calc = crc4_next(crc_calc, sr[i]);
    crc_calc = crc4_next(crc_calc, 1'b1);
    for (int i = 2; i >= 0; i--) crc_calc = crc4_next(crc_calc, cmd_op[i]);
  end

  // Priority: a length/framing fault masks CRC, a CRC fault masks the opcode.
  always_comb begin
    rec_err          = '0;
    rec_err.err_data = frame_err || (cnt != CNT_FULL);
    rec_err.err_crc  = !rec_err.err_data && (crc_calc != frame_byte[3:0]);
    rec_err.err_op   = !rec_err.err_data && !rec_err.err_crc && !op_is_valid(cmd_op);
  end

  assign any_err = rec_err.err_data || rec_err.err_crc || rec_err.err_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= 3'b000;
      out_err   <= 3'b000;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_push) begin
        // Extra bytes keep shifting so the oldest fall off the top.
        sr <= PKT_W'({sr, frame_byte});
        if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
      end
      if (complete) begin
        sr  <= '0;
        cnt <= '0;
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= any_err ? '0 : sr;
          out_op    <= any_err ? 3'b000 : cmd_op;
          out_err   <= rec_err;
        end else begin
          // Held record wins; the newcomer is dropped and flagged.
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
module tb_alu_serial_rx;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  op;
    logic [2:0]  err;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic sin_a = 1'b1, sin_b = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1;
  int   mode_a = 1, mode_b = 1;     // 0: ready low, 1: ready high, 2: random

  logic        vld_a, ovr_a, vld_b, ovr_b;
  logic [63:0] dat_a;
  logic [47:0] dat_b;
  logic [2:0]  op_a, err_a, op_b, err_b;

  alu_serial_rx #(.DATA_W(32), .N_OPERANDS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .sin(sin_a), .out_valid(vld_a), .out_ready(rdy_a),
    .out_data(dat_a), .out_op(op_a), .out_err(err_a), .overrun(ovr_a));

  alu_serial_rx #(.DATA_W(16), .N_OPERANDS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .sin(sin_b), .out_valid(vld_b), .out_ready(rdy_b),
    .out_data(dat_b), .out_op(op_b), .out_err(err_b), .overrun(ovr_b));

  int   n_cmp = 0, n_bad = 0;
  int   ovr_cnt_a = 0, ovr_cnt_b = 0;
  rec_t exp_a[$], exp_b[$];
  logic [7:0] tx_bytes[$];

  // Ready drivers: change well after the edge, sampled by the monitors at negedge.
  always @(posedge clk) begin
    #2;
    rdy_a = (mode_a == 0) ? 1'b0 : (mode_a == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    rdy_b = (mode_b == 0) ? 1'b0 : (mode_b == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitors / scoreboard ----------------
  rec_t r_a, snap_a, r_b, snap_b;
  bit   held_a = 0, held_b = 0;

  always @(negedge clk) begin
    if (!rst_n) held_a = 0;
    else begin
      if (vld_a && rdy_a) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_bad++;
          $display("FAIL rec_a: unexpected record data=%h op=%b err=%b", dat_a, op_a, err_a);
        end else begin
          r_a = exp_a.pop_front();
          if (dat_a !== r_a.data || op_a !== r_a.op || err_a !== r_a.err) begin
            n_bad++;
            $display("FAIL rec_a: got data=%h op=%b err=%b, expected data=%h op=%b err=%b",
                     dat_a, op_a, err_a, r_a.data, r_a.op, r_a.err);
          end
        end
      end
      if (ovr_a) ovr_cnt_a++;
      if (vld_a && !rdy_a) begin
        if (held_a) begin
          n_cmp++;
          if (dat_a !== snap_a.data || op_a !== snap_a.op || err_a !== snap_a.err) begin
            n_bad++;
            $display("FAIL hold_a: record changed to %h/%b/%b, required %h/%b/%b",
                     dat_a, op_a, err_a, snap_a.data, snap_a.op, snap_a.err);
          end
        end
        held_a = 1;
        snap_a = '{data: dat_a, op: op_a, err: err_a};
      end else held_a = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) held_b = 0;
    else begin
      if (vld_b && rdy_b) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_bad++;
          $display("FAIL rec_b: unexpected record data=%h op=%b err=%b", dat_b, op_b, err_b);
        end else begin
          r_b = exp_b.pop_front();
          if ({16'h0, dat_b} !== r_b.data || op_b !== r_b.op || err_b !== r_b.err) begin
            n_bad++;
            $display("FAIL rec_b: got data=%h op=%b err=%b, expected data=%h op=%b err=%b",
                     dat_b, op_b, err_b, r_b.data, r_b.op, r_b.err);
          end
        end
      end
      if (ovr_b) ovr_cnt_b++;
      if (vld_b && !rdy_b) begin
        if (held_b) begin
          n_cmp++;
          if ({16'h0, dat_b} !== snap_b.data || op_b !== snap_b.op || err_b !== snap_b.err) begin
            n_bad++;
            $display("FAIL hold_b: record changed to %h/%b/%b, required %h/%b/%b",
                     dat_b, op_b, err_b, snap_b.data, snap_b.op, snap_b.err);
          end
        end
        held_b = 1;
        snap_b = '{data: {16'h0, dat_b}, op: op_b, err: err_b};
      end else held_b = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int bpp(input int id);
    return (id == 0) ? 8 : 6;
  endfunction

  // CRC of the packet bit stream: every byte MSB first, then a 1, then the op.
  function automatic logic [3:0] ref_crc(input logic [2:0] op);
    logic [3:0] c = 4'h0;
    foreach (tx_bytes[i])
      for (int k = 7; k >= 0; k--) c = crc4_next(c, tx_bytes[i][k]);
    c = crc4_next(c, 1'b1);
    for (int k = 2; k >= 0; k--) c = crc4_next(c, op[k]);
    return c;
  endfunction

  function automatic rec_t model(input int id, input logic [7:0] cmd);
    rec_t r = '{data: 64'h0, op: 3'b000, err: 3'b000};
    logic [63:0] d = 64'h0;
    if (tx_bytes.size() != bpp(id)) r.err = 3'b100;
    else if (ref_crc(cmd[6:4]) != cmd[3:0]) r.err = 3'b010;
    else if (!(cmd[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) r.err = 3'b001;
    else begin
      foreach (tx_bytes[i]) d = (d << 8) | 64'(tx_bytes[i]);
      r.data = d;
      r.op   = cmd[6:4];
    end
    return r;
  endfunction

  function automatic logic [7:0] good_cmd(input logic [2:0] op);
    return {1'b0, op, ref_crc(op)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input int id, input logic b);
    @(negedge clk);
    if (id == 0) sin_a = b; else sin_b = b;
  endtask

  task automatic send_idle(input int id, input int n);
    for (int i = 0; i < n; i++) send_bit(id, 1'b1);
  endtask

  task automatic send_frame(input int id, input logic typ, input logic [7:0] b, input logic stop);
    send_bit(id, 1'b0);
    send_bit(id, typ);
    for (int k = 7; k >= 0; k--) send_bit(id, b[k]);
    send_bit(id, stop);
  endtask

  task automatic push_rec(input int id, input rec_t r);
    if (id == 0) exp_a.push_back(r); else exp_b.push_back(r);
  endtask

  task automatic send_packet(input int id, input logic [7:0] cmd, input bit push);
    foreach (tx_bytes[i]) begin
      send_frame(id, FRAME_DATA, tx_bytes[i], 1'b1);
      send_idle(id, $urandom_range(0, 2));
    end
    if (push) push_rec(id, model(id, cmd));
    send_frame(id, FRAME_CMD, cmd, 1'b1);
  endtask

  task automatic fill(input int n, input bit zero);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(zero ? 8'h00 : 8'($urandom));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drain(input int id);
    int k = 0;
    while (((id == 0) ? exp_a.size() : exp_b.size()) != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check((id == 0) ? "drain_a" : "drain_b", 64'((id == 0) ? exp_a.size() : exp_b.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          n, sel, ovr_base, k;
    logic [2:0]  op;
    logic [7:0]  cmd;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", 64'(vld_a), 64'd0);
    check("rst_data_a", dat_a, 64'd0);
    check("rst_op_err_a", {58'd0, op_a, err_a}, 64'd0);
    check("rst_ovr_a", 64'(ovr_a), 64'd0);
    check("rst_valid_b", 64'(vld_b), 64'd0);
    check("rst_data_b", 64'(dat_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_idle(0, 2);

    // All-zero packet, AND, crc 0xB: clean, valid one cycle after the stop edge.
    fill(8, 1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b000});
    send_packet(0, 8'h0B, 0);
    @(posedge clk); #1;
    check("latency_stop_edge", 64'(vld_a), 64'd0);
    @(posedge clk); #1;
    check("latency_next_edge", 64'(vld_a), 64'd1);
    send_idle(0, 3);

    fill(8, 1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b010});
    send_packet(0, 8'h0A, 0);
    send_idle(0, 3);

    fill(8, 1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b001});
    send_packet(0, 8'h2D, 0);
    send_idle(0, 3);

    fill(7, 1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b100});
    send_packet(0, 8'h0B, 0);
    send_idle(0, 3);

    fill(0, 1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b100});
    send_packet(0, 8'h0B, 0);
    send_idle(0, 3);

    fill(9, 0);
    send_packet(0, good_cmd(3'b100), 1);
    send_idle(0, 3);

    // Bad stop bit in the third DATA frame, then a clean packet.
    send_frame(0, FRAME_DATA, 8'h11, 1'b1);
    send_frame(0, FRAME_DATA, 8'h22, 1'b1);
    push_rec(0, '{data: 64'h0, op: 3'b000, err: 3'b100});
    send_frame(0, FRAME_DATA, 8'h33, 1'b0);
    send_idle(0, 3);
    fill(8, 0);
    send_packet(0, good_cmd(3'b001), 1);
    send_idle(0, 3);
    drain(0);

    // Overrun: two good packets complete with the consumer stalled.
    mode_a   = 0;
    ovr_base = ovr_cnt_a;
    fill(8, 0);
    send_packet(0, good_cmd(3'b101), 1);
    send_idle(0, 2);
    fill(8, 0);
    send_packet(0, good_cmd(3'b000), 0);
    send_idle(0, 4);
    check("overrun_pulses", 64'(ovr_cnt_a - ovr_base), 64'd1);
    check("held_valid", 64'(vld_a), 64'd1);
    mode_a = 1;
    @(posedge clk); #3;
    @(posedge clk); #1;
    check("valid_drop_after_accept", 64'(vld_a), 64'd0);
    drain(0);

    // Randomised packets with a random consumer.
    mode_a = 2;
    for (int p = 0; p < 20; p++) begin
      sel = $urandom_range(0, 9);
      n   = (sel < 7) ? 8 : (sel == 7) ? 7 : (sel == 8) ? 9 : 0;
      fill(n, 0);
      op  = 3'($urandom_range(0, 7));
      cmd = good_cmd(op);
      if ($urandom_range(0, 3) == 0) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
      cmd[7] = 1'($urandom_range(0, 1));
      send_packet(0, cmd, 1);
      send_idle(0, $urandom_range(0, 3));
    end
    drain(0);
    mode_a = 1;

    // 16-bit x 3 operands.
    tx_bytes = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    push_rec(1, '{data: 64'h0000_1234_5678_9ABC, op: 3'b100, err: 3'b000});
    send_packet(1, good_cmd(3'b100), 0);
    send_idle(1, 3);
    mode_b = 2;
    for (int p = 0; p < 8; p++) begin
      sel = $urandom_range(0, 5);
      fill((sel == 0) ? 5 : 6, 0);
      op  = 3'($urandom_range(0, 7));
      cmd = good_cmd(op);
      if (sel == 1) cmd[3:0] = ~cmd[3:0];
      send_packet(1, cmd, 1);
      send_idle(1, $urandom_range(0, 3));
    end
    drain(1);

    // Reset with a record held and a packet half received.
    mode_b = 0;
    fill(6, 0);
    send_packet(1, good_cmd(3'b000), 0);
    k = 0;
    while (!vld_b && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("b_held_before_reset", 64'(vld_b), 64'd1);
    for (int i = 0; i < 3; i++) send_frame(1, FRAME_DATA, 8'($urandom), 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sin_b = 1'b1;
    #1;
    check("midreset_valid_b", 64'(vld_b), 64'd0);
    check("midreset_data_b", 64'(dat_b), 64'd0);
    check("midreset_op_err_b", {58'd0, op_b, err_b}, 64'd0);
    check("midreset_ovr_b", 64'(ovr_b), 64'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mode_b = 1;
    send_idle(1, 2);
    fill(6, 0);
    send_packet(1, good_cmd(3'b101), 1);
    send_idle(1, 3);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
